// File: rtl/id_stage_if.sv
// id_stage_if: signal bundle around the instruction-decode stage.
//   slave  modport - seen by id_stage: fetch inputs (pc_in, instruction_in),
//                    status flags, hazard stall, WB write port in; decoded
//                    control, data fields, operand values and source indices out.
//   master modport - seen by the surrounding pipeline (or a bench): the reverse.
interface id_stage_if #(
    parameter int unsigned WORD_LEN = 32
);
    // Fetch side
    logic [WORD_LEN-1:0] pc_in;
    logic [31:0]         instruction_in;
    logic [3:0]          status_reg;
    logic                hazard;

    // Write-back port
    logic                wb_wb_en;
    logic [3:0]          wb_dest;
    logic [WORD_LEN-1:0] wb_value;

    // Decoded outputs towards the ID/EX register and hazard unit
    logic [WORD_LEN-1:0] pc_out;
    logic [3:0]          exe_cmd;
    logic                mem_r_en;
    logic                mem_w_en;
    logic                wb_en;
    logic                s;
    logic                b;
    logic                imm;
    logic [11:0]         shift_operand;
    logic [23:0]         signed_imm_24;
    logic [3:0]          dest;
    logic [WORD_LEN-1:0] val_rn;
    logic [WORD_LEN-1:0] val_rm;
    logic [3:0]          src1;
    logic [3:0]          src2;
    logic                two_src;

    modport slave (
        input  pc_in, instruction_in, status_reg, hazard,
               wb_wb_en, wb_dest, wb_value,
        output pc_out, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, imm,
               shift_operand, signed_imm_24, dest, val_rn, val_rm,
               src1, src2, two_src
    );

    modport master (
        output pc_in, instruction_in, status_reg, hazard,
               wb_wb_en, wb_dest, wb_value,
        input  pc_out, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, imm,
               shift_operand, signed_imm_24, dest, val_rn, val_rm,
               src1, src2, two_src
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: ARM-style instruction decode stage.
//   Holds register file R0..R14 (index 15 unbacked, reads as 0), decodes the
//   fetched instruction into ALU/memory/branch control, evaluates the condition
//   field against {N,Z,C,V} and turns the instruction into a bubble when the
//   condition fails or the hazard unit stalls. All outputs are combinational;
//   the downstream ID/EX register is the pipeline boundary.
// Ports:
//   clk  - rising-edge clock (register file writes)
//   rst  - asynchronous active-high reset, loads Ri = i
//   bus  - id_stage_if.slave: fetch/status/hazard/WB inputs, decoded outputs
// Build option:
//   ID_WB_BYPASS_EN - when defined, a WB write to the register being read is
//                     forwarded to val_rn/val_rm in the same cycle.
module id_stage #(
    parameter int unsigned WORD_LEN  = 32,
    parameter int unsigned REG_COUNT = 15
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CMD_W = 4;

    localparam logic [IDX_W-1:0] IDX_UNBACKED = 4'hF;

    // Instruction modes
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes
    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_EOR = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_ADC = 4'b0101;
    localparam logic [3:0] OPC_SBC = 4'b0110;
    localparam logic [3:0] OPC_TST = 4'b1000;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;
    localparam logic [3:0] OPC_MVN = 4'b1111;

    // ALU commands
    localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

    // Condition codes
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;

    // Instruction fields
    logic [3:0]       cond;
    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic             s_bit;
    logic             imm_bit;
    logic [IDX_W-1:0] rn_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rm_idx;

    assign cond    = bus.instruction_in[31:28];
    assign mode    = bus.instruction_in[27:26];
    assign imm_bit = bus.instruction_in[25];
    assign opcode  = bus.instruction_in[24:21];
    assign s_bit   = bus.instruction_in[20];
    assign rn_idx  = bus.instruction_in[19:16];
    assign rd_idx  = bus.instruction_in[15:12];
    assign rm_idx  = bus.instruction_in[3:0];

    // ------------------------------------------------------------------
    // Register file R0..R14
    // ------------------------------------------------------------------
    logic [WORD_LEN-1:0] regs_q [REG_COUNT];
    logic [WORD_LEN-1:0] regs_d [REG_COUNT];

    // Next-state: WB write lands on the matching entry; index 15 matches none.
    always_comb begin
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_d[i] = regs_q[i];
            if (bus.wb_wb_en && (bus.wb_dest == IDX_W'(i))) begin
                regs_d[i] = bus.wb_value;
            end
        end
    end

    // Reset loads each register with its own index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= WORD_LEN'(i);
            end
        end else begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source selection and register reads
    // ------------------------------------------------------------------
    logic                is_store;
    logic [IDX_W-1:0]    src2_idx;
    logic [WORD_LEN-1:0] rn_stored;
    logic [WORD_LEN-1:0] rm_stored;

    // Store decode ignores the bubble so the hazard unit still sees Rd as src2.
    assign is_store = (mode == MODE_MEM) && !s_bit;
    assign src2_idx = is_store ? rd_idx : rm_idx;

    // Combinational read; unbacked index 15 falls through to zero.
    always_comb begin
        rn_stored = '0;
        rm_stored = '0;
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            if (rn_idx == IDX_W'(i)) begin
                rn_stored = regs_q[i];
            end
            if (src2_idx == IDX_W'(i)) begin
                rm_stored = regs_q[i];
            end
        end
    end

`ifdef ID_WB_BYPASS_EN
    // Same-cycle forwarding of the WB value; suppressed during reset since
    // the write itself is discarded then.
    logic byp_rn;
    logic byp_rm;

    assign byp_rn = !rst && bus.wb_wb_en && (bus.wb_dest != IDX_UNBACKED)
                    && (bus.wb_dest == rn_idx);
    assign byp_rm = !rst && bus.wb_wb_en && (bus.wb_dest != IDX_UNBACKED)
                    && (bus.wb_dest == src2_idx);

    assign bus.val_rn = byp_rn ? bus.wb_value : rn_stored;
    assign bus.val_rm = byp_rm ? bus.wb_value : rm_stored;
`else
    // New WB values become visible only after the clock edge.
    assign bus.val_rn = rn_stored;
    assign bus.val_rm = rm_stored;
`endif

    // ------------------------------------------------------------------
    // Control decode (before bubble)
    // ------------------------------------------------------------------
    logic [CMD_W-1:0] dec_cmd;
    logic             dec_mem_r;
    logic             dec_mem_w;
    logic             dec_wb;
    logic             dec_s;
    logic             dec_b;

    always_comb begin
        dec_cmd   = EXE_NOP;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_wb    = 1'b0;
        dec_s     = 1'b0;
        dec_b     = 1'b0;
        case (mode)
            MODE_DP: begin
                dec_s  = s_bit;
                dec_wb = 1'b1;
                case (opcode)
                    OPC_MOV: dec_cmd = EXE_MOV;
                    OPC_MVN: dec_cmd = EXE_MVN;
                    OPC_ADD: dec_cmd = EXE_ADD;
                    OPC_ADC: dec_cmd = EXE_ADC;
                    OPC_SUB: dec_cmd = EXE_SUB;
                    OPC_SBC: dec_cmd = EXE_SBC;
                    OPC_AND: dec_cmd = EXE_AND;
                    OPC_ORR: dec_cmd = EXE_ORR;
                    OPC_EOR: dec_cmd = EXE_EOR;
                    // Compare/test only set flags, never write Rd.
                    OPC_CMP: begin
                        dec_cmd = EXE_SUB;
                        dec_wb  = 1'b0;
                    end
                    OPC_TST: begin
                        dec_cmd = EXE_AND;
                        dec_wb  = 1'b0;
                    end
                    default: begin
                        dec_cmd = EXE_NOP;
                        dec_wb  = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                dec_cmd   = EXE_ADD;
                dec_s     = s_bit;
                dec_mem_r = s_bit;
                dec_wb    = s_bit;
                dec_mem_w = !s_bit;
            end
            MODE_BR: begin
                dec_b = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Condition evaluation against {N,Z,C,V}
    // ------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;

    assign flag_n = bus.status_reg[3];
    assign flag_z = bus.status_reg[2];
    assign flag_c = bus.status_reg[1];
    assign flag_v = bus.status_reg[0];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            CC_EQ:   cond_pass = flag_z;
            CC_NE:   cond_pass = !flag_z;
            CC_CS:   cond_pass = flag_c;
            CC_CC:   cond_pass = !flag_c;
            CC_MI:   cond_pass = flag_n;
            CC_PL:   cond_pass = !flag_n;
            CC_VS:   cond_pass = flag_v;
            CC_VC:   cond_pass = !flag_v;
            CC_HI:   cond_pass = flag_c && !flag_z;
            CC_LS:   cond_pass = !flag_c || flag_z;
            CC_GE:   cond_pass = (flag_n == flag_v);
            CC_LT:   cond_pass = (flag_n != flag_v);
            CC_GT:   cond_pass = !flag_z && (flag_n == flag_v);
            CC_LE:   cond_pass = flag_z || (flag_n != flag_v);
            CC_AL:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bubble insertion and output drive
    // ------------------------------------------------------------------
    logic bubble;

    assign bubble = bus.hazard || !cond_pass;

    // Only the control bits are squashed; data fields stay for the hazard unit.
    always_comb begin
        bus.exe_cmd  = dec_cmd;
        bus.mem_r_en = dec_mem_r;
        bus.mem_w_en = dec_mem_w;
        bus.wb_en    = dec_wb;
        bus.s        = dec_s;
        bus.b        = dec_b;
        if (bubble) begin
            bus.exe_cmd  = EXE_NOP;
            bus.mem_r_en = 1'b0;
            bus.mem_w_en = 1'b0;
            bus.wb_en    = 1'b0;
            bus.s        = 1'b0;
            bus.b        = 1'b0;
        end
    end

    assign bus.pc_out        = bus.pc_in;
    assign bus.imm           = imm_bit;
    assign bus.shift_operand = bus.instruction_in[11:0];
    assign bus.signed_imm_24 = bus.instruction_in[23:0];
    assign bus.dest          = rd_idx;
    assign bus.src1          = rn_idx;
    assign bus.src2          = src2_idx;
    // two_src uses the raw store decode so a stalled store still reports Rd.
    assign bus.two_src       = !imm_bit || is_store;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. A behavioural model (register
// array, opcode lookup table, condition rule) predicts every output each cycle;
// directed steps additionally pin hand-computed literal values.
module tb_id_stage;

    logic clk;
    logic rst;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ALU command per data-processing opcode, -1 = undefined opcode.
    localparam int DP_CMD [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    int vectors;
    int miscompares;
    logic [31:0] mregs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] idx);
        return (idx == 4'hF) ? 32'h0 : mregs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 32'(i);
    endtask

    // Condition: bit 0 of the code inverts a base test selected by bits [3:1];
    // 1111 is never-execute.
    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return base ^ cc[0];
    endfunction

    // Full-output check against the model.
    task automatic check_all();
        logic [31:0] ins;
        logic [1:0]  mode;
        logic [3:0]  opc;
        bit          sb, store, e_r, e_w, e_wb, e_s, e_b, byp1, byp2;
        int          e_cmd;
        logic [3:0]  e_src2;
        logic [31:0] e_rn, e_rm;
        ins = bus.instruction_in;
        mode = ins[27:26];
        opc = ins[24:21];
        sb = ins[20];
        e_cmd = 0; e_r = 0; e_w = 0; e_wb = 0; e_s = 0; e_b = 0;
        if (mode == 2'd0) begin
            e_s = sb;
            if (DP_CMD[opc] >= 0) begin
                e_cmd = DP_CMD[opc];
                e_wb  = !(opc == 4'd10 || opc == 4'd8);
            end
        end else if (mode == 2'd1) begin
            e_cmd = 2; e_s = sb;
            if (sb) begin e_r = 1; e_wb = 1; end
            else    e_w = 1;
        end else if (mode == 2'd2) begin
            e_b = 1;
        end
        store = (mode == 2'd1) && !sb;
        if (bus.hazard || !cond_ok(ins[31:28], bus.status_reg)) begin
            e_cmd = 0; e_r = 0; e_w = 0; e_wb = 0; e_s = 0; e_b = 0;
        end
        e_src2 = store ? ins[15:12] : ins[3:0];
        byp1 = BYPASS && !rst && bus.wb_wb_en && bus.wb_dest != 4'hF && bus.wb_dest == ins[19:16];
        byp2 = BYPASS && !rst && bus.wb_wb_en && bus.wb_dest != 4'hF && bus.wb_dest == e_src2;
        e_rn = byp1 ? bus.wb_value : mread(ins[19:16]);
        e_rm = byp2 ? bus.wb_value : mread(e_src2);

        chk("pc_out",        bus.pc_out, bus.pc_in);
        chk("exe_cmd",       32'(bus.exe_cmd), 32'(e_cmd));
        chk("mem_r_en",      32'(bus.mem_r_en), 32'(e_r));
        chk("mem_w_en",      32'(bus.mem_w_en), 32'(e_w));
        chk("wb_en",         32'(bus.wb_en), 32'(e_wb));
        chk("s",             32'(bus.s), 32'(e_s));
        chk("b",             32'(bus.b), 32'(e_b));
        chk("imm",           32'(bus.imm), 32'(ins[25]));
        chk("shift_operand", 32'(bus.shift_operand), 32'(ins[11:0]));
        chk("signed_imm_24", 32'(bus.signed_imm_24), 32'(ins[23:0]));
        chk("dest",          32'(bus.dest), 32'(ins[15:12]));
        chk("src1",          32'(bus.src1), 32'(ins[19:16]));
        chk("src2",          32'(bus.src2), 32'(e_src2));
        chk("two_src",       32'(bus.two_src), 32'(!ins[25] || store));
        chk("val_rn",        bus.val_rn, e_rn);
        chk("val_rm",        bus.val_rm, e_rm);
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    // Rising edge: commit the WB write into the model, then move off the edge.
    task automatic advance();
        @(posedge clk);
        if (!rst && bus.wb_wb_en && bus.wb_dest != 4'hF) mregs[bus.wb_dest] = bus.wb_value;
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [3:0] st, input logic hz,
                         input logic we, input logic [3:0] wd, input logic [31:0] wv);
        bus.pc_in          = $urandom;
        bus.instruction_in = ins;
        bus.status_reg     = st;
        bus.hazard         = hz;
        bus.wb_wb_en       = we;
        bus.wb_dest        = wd;
        bus.wb_value       = wv;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        model_reset();
        drive(32'hE0801002, 4'h0, 1'b0, 1'b1, 4'd2, 32'hDEAD_BEEF);
        sample();
        chk("rst_write_blocked", bus.val_rm, 32'd2);
        advance();
        sample();
        advance();
        rst = 1'b0;

        // Sweep every source index through Rn and Rm.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] k;
            k = 4'(i);
            drive({4'hE, 8'h00, k, 4'h0, 8'h00, k}, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
            sample();
            chk("sweep_rn", bus.val_rn, (i == 15) ? 32'h0 : 32'(i));
            chk("sweep_rm", bus.val_rm, (i == 15) ? 32'h0 : 32'(i));
            advance();
        end

        // MOV R1,#5
        drive(32'hE3A01005, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        sample();
        chk("mov_cmd",   32'(bus.exe_cmd), 32'h1);
        chk("mov_wb",    32'(bus.wb_en), 32'h1);
        chk("mov_imm",   32'(bus.imm), 32'h1);
        chk("mov_dest",  32'(bus.dest), 32'h1);
        chk("mov_shop",  32'(bus.shift_operand), 32'h005);
        chk("mov_2src",  32'(bus.two_src), 32'h0);
        advance();

        // ADD R2,R0,R1 with a simultaneous write of R1
        drive(32'hE0802001, 4'h0, 1'b0, 1'b1, 4'd1, 32'h55);
        sample();
        chk("add_cmd",  32'(bus.exe_cmd), 32'h2);
        chk("add_src2", 32'(bus.src2), 32'h1);
        chk("add_rm_same_cycle", bus.val_rm, BYPASS ? 32'h55 : 32'h1);
        advance();
        drive(32'hE0802001, 4'h0, 1'b0, 1'b0, 4'd1, 32'h0);
        sample();
        chk("add_rm_after_edge", bus.val_rm, 32'h55);
        advance();

        // STR R3,[R0,#4], then stalled
        drive(32'hE4003004, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        sample();
        chk("str_memw", 32'(bus.mem_w_en), 32'h1);
        chk("str_wb",   32'(bus.wb_en), 32'h0);
        chk("str_cmd",  32'(bus.exe_cmd), 32'h2);
        chk("str_src2", 32'(bus.src2), 32'h3);
        chk("str_2src", 32'(bus.two_src), 32'h1);
        advance();
        drive(32'hE4003004, 4'h0, 1'b1, 1'b0, 4'd0, 32'h0);
        sample();
        chk("str_hz_ctrl", {26'h0, bus.exe_cmd, bus.mem_w_en, bus.mem_r_en},  32'h0);
        chk("str_hz_src2", 32'(bus.src2), 32'h3);
        advance();

        // BEQ with Z clear then set
        drive(32'h0A000003, 4'b0000, 1'b0, 1'b0, 4'd0, 32'h0);
        sample();
        chk("beq_nz_b", 32'(bus.b), 32'h0);
        advance();
        drive(32'h0A000003, 4'b0100, 1'b0, 1'b0, 4'd0, 32'h0);
        sample();
        chk("beq_z_b",   32'(bus.b), 32'h1);
        chk("beq_z_off", 32'(bus.signed_imm_24), 32'h000003);
        advance();

        // Write to index 15 is discarded
        drive(32'hE0800000, 4'h0, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF);
        sample();
        advance();
        drive(32'hE08F000E, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        sample();
        chk("r15_reads_zero", bus.val_rn, 32'h0);
        chk("r14_unchanged",  bus.val_rm, 32'd14);
        advance();

        // Randomised traffic with one asynchronous reset in the middle
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            drive(ins, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            if (n == 1000) begin
                rst = 1'b1;
                model_reset();
            end
            sample();
            advance();
            if (n == 1000) rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
